// File: rtl/alu_share_arbiter.sv
// Two requesters share one combinational 32-bit ALU. Each requester has its own
// registered response slot. Arbitration is round-robin or fixed-priority.
`timescale 1ns/1ps
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [2:0]            req0_op,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_result,
  output logic [2:0]            rsp0_flags,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [2:0]            req1_op,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_result,
  output logic [2:0]            rsp1_flags
);

  // Returns {overflow, carry/borrow, zero, result}. When op[2] is set, the adder subtracts.
  function automatic logic [DATA_WIDTH+2:0] alu_eval(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [2:0]            op
  );
    logic                  sub;
    logic [DATA_WIDTH-1:0] b_eff;
    logic [DATA_WIDTH:0]   sum;
    logic                  ovf;
    logic                  cry;
    logic [DATA_WIDTH-1:0] res;
    sub   = op[2];
    b_eff = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, sub};
    ovf   = (a[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
    cry   = sub ? ~sum[DATA_WIDTH] : sum[DATA_WIDTH];
    case (op)
      3'b000:  res = a & b;
      3'b001:  res = a | b;
      3'b010:  res = sum[DATA_WIDTH-1:0];
      3'b011:  res = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      3'b100:  res = a ^ b;
      3'b101:  res = ~(a | b);
      3'b110:  res = sum[DATA_WIDTH-1:0];
      3'b111:  res = {{(DATA_WIDTH-1){1'b0}}, (sum[DATA_WIDTH-1] ^ ovf)};
      default: res = {DATA_WIDTH{1'b0}};
    endcase
    return {ovf, cry, (res == {DATA_WIDTH{1'b0}}), res};
  endfunction

  logic                  rsp0_valid_r;
  logic [DATA_WIDTH-1:0] rsp0_result_r;
  logic [2:0]            rsp0_flags_r;
  logic                  rsp1_valid_r;
  logic [DATA_WIDTH-1:0] rsp1_result_r;
  logic [2:0]            rsp1_flags_r;
  logic                  rr_ptr_r;

  logic                  elig0_s;
  logic                  elig1_s;
  logic                  grant0_s;
  logic                  grant1_s;
  logic [DATA_WIDTH-1:0] alu_a_s;
  logic [DATA_WIDTH-1:0] alu_b_s;
  logic [2:0]            alu_op_s;
  logic [DATA_WIDTH+2:0] alu_out_s;

  // Eligibility and grant; a slot that drains this cycle can accept a new request.
  always_comb begin
    elig0_s  = req0_valid && (!rsp0_valid_r || rsp0_ready);
    elig1_s  = req1_valid && (!rsp1_valid_r || rsp1_ready);
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (elig0_s && elig1_s) begin
      if ((FIXED_PRIO == 1'b1) || (rr_ptr_r == 1'b0)) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
    end else begin
      grant0_s = elig0_s;
      grant1_s = elig1_s;
    end
  end

  // Shared ALU operand mux; idle cycles present zeros and AND.
  always_comb begin
    alu_a_s  = {DATA_WIDTH{1'b0}};
    alu_b_s  = {DATA_WIDTH{1'b0}};
    alu_op_s = 3'b000;
    if (grant0_s) begin
      alu_a_s  = req0_a;
      alu_b_s  = req0_b;
      alu_op_s = req0_op;
    end else if (grant1_s) begin
      alu_a_s  = req1_a;
      alu_b_s  = req1_b;
      alu_op_s = req1_op;
    end else begin
      alu_op_s = 3'b000;
    end
    alu_out_s = alu_eval(alu_a_s, alu_b_s, alu_op_s);
  end

  // Response slots and round-robin pointer; contention hands priority to the loser.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_r  <= 1'b0;
      rsp0_result_r <= {DATA_WIDTH{1'b0}};
      rsp0_flags_r  <= 3'b000;
      rsp1_valid_r  <= 1'b0;
      rsp1_result_r <= {DATA_WIDTH{1'b0}};
      rsp1_flags_r  <= 3'b000;
      rr_ptr_r      <= 1'b0;
    end else begin
      if (grant0_s) begin
        rsp0_valid_r  <= 1'b1;
        rsp0_result_r <= alu_out_s[DATA_WIDTH-1:0];
        rsp0_flags_r  <= alu_out_s[DATA_WIDTH+2:DATA_WIDTH];
      end else if (rsp0_ready) begin
        rsp0_valid_r  <= 1'b0;
      end else begin
        rsp0_valid_r  <= rsp0_valid_r;
      end
      if (grant1_s) begin
        rsp1_valid_r  <= 1'b1;
        rsp1_result_r <= alu_out_s[DATA_WIDTH-1:0];
        rsp1_flags_r  <= alu_out_s[DATA_WIDTH+2:DATA_WIDTH];
      end else if (rsp1_ready) begin
        rsp1_valid_r  <= 1'b0;
      end else begin
        rsp1_valid_r  <= rsp1_valid_r;
      end
      if (elig0_s && elig1_s) begin
        rr_ptr_r <= grant0_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  assign req0_ready  = grant0_s;
  assign req1_ready  = grant1_s;
  assign rsp0_valid  = rsp0_valid_r;
  assign rsp0_result = rsp0_result_r;
  assign rsp0_flags  = rsp0_flags_r;
  assign rsp1_valid  = rsp1_valid_r;
  assign rsp1_result = rsp1_result_r;
  assign rsp1_flags  = rsp1_flags_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance share one stimulus.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  logic        clk;
  logic        rst;
  logic        r0v, r1v, s0r, s1r;
  logic [31:0] r0a, r0b, r1a, r1b;
  logic [2:0]  r0op, r1op;
  logic        q0rdy, q1rdy, s0v, s1v;
  logic [31:0] s0res, s1res;
  logic [2:0]  s0fl, s1fl;
  logic        fq0rdy, fq1rdy, fs0v, fs1v;
  logic [31:0] fs0res, fs1res;
  logic [2:0]  fs0fl, fs1fl;
  int          vectors;
  int          miscompares;

  alu_share_arbiter #(.DATA_WIDTH(32), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(q0rdy), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
    .rsp0_valid(s0v), .rsp0_ready(s0r), .rsp0_result(s0res), .rsp0_flags(s0fl),
    .req1_valid(r1v), .req1_ready(q1rdy), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
    .rsp1_valid(s1v), .rsp1_ready(s1r), .rsp1_result(s1res), .rsp1_flags(s1fl)
  );

  alu_share_arbiter #(.DATA_WIDTH(32), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(fq0rdy), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
    .rsp0_valid(fs0v), .rsp0_ready(s0r), .rsp0_result(fs0res), .rsp0_flags(fs0fl),
    .req1_valid(r1v), .req1_ready(fq1rdy), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
    .rsp1_valid(fs1v), .rsp1_ready(s1r), .rsp1_result(fs1res), .rsp1_flags(fs1fl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; r0v = 1'b1; r1v = 1'b1; s0r = 1'b1; s1r = 1'b1;
    r0a = 32'd1; r0b = 32'd1; r0op = 3'b010;
    r1a = 32'd1; r1b = 32'd1; r1op = 3'b010;

    // Reset held two cycles with both requests pending
    tick();
    chk("rst_q0rdy", {31'd0, q0rdy}, 32'd0);
    chk("rst_q1rdy", {31'd0, q1rdy}, 32'd0);
    chk("rst_fq0rdy", {31'd0, fq0rdy}, 32'd0);
    tick();
    chk("rst_s0v", {31'd0, s0v}, 32'd0);
    chk("rst_s1v", {31'd0, s1v}, 32'd0);
    chk("rst_s0res", s0res, 32'd0);
    chk("rst_s0fl", {29'd0, s0fl}, 32'd0);
    chk("rst_s1res", s1res, 32'd0);
    chk("rst_s1fl", {29'd0, s1fl}, 32'd0);
    rst = 1'b0; r0v = 1'b0; r1v = 1'b0;
    #1;
    chk("idle_q0rdy", {31'd0, q0rdy}, 32'd0);

    // Single ADD with signed overflow
    r0v = 1'b1; r0a = 32'h7FFF_FFFF; r0b = 32'd1; r0op = 3'b010;
    #1;
    chk("add_q0rdy", {31'd0, q0rdy}, 32'd1);
    chk("add_q1rdy", {31'd0, q1rdy}, 32'd0);
    tick();
    chk("add_s0v", {31'd0, s0v}, 32'd1);
    chk("add_s0res", s0res, 32'h8000_0000);
    chk("add_s0fl", {29'd0, s0fl}, {29'd0, 3'b100});
    r0v = 1'b0;
    tick();
    chk("drain_s0v", {31'd0, s0v}, 32'd0);

    // req1 SUB, SLTU, SLT back to back
    r1v = 1'b1; r1a = 32'd5; r1b = 32'd5; r1op = 3'b110;
    #1;
    chk("sub_q1rdy", {31'd0, q1rdy}, 32'd1);
    tick();
    chk("sub_s1v", {31'd0, s1v}, 32'd1);
    chk("sub_s1res", s1res, 32'd0);
    chk("sub_s1fl", {29'd0, s1fl}, {29'd0, 3'b001});
    r1a = 32'd1; r1b = 32'd2; r1op = 3'b011;
    #1;
    chk("sltu_q1rdy_b2b", {31'd0, q1rdy}, 32'd1);
    tick();
    chk("sltu_s1v", {31'd0, s1v}, 32'd1);
    chk("sltu_s1res", s1res, 32'd1);
    chk("sltu_s1fl", {29'd0, s1fl}, {29'd0, 3'b000});
    r1a = 32'hFFFF_FFFF; r1b = 32'd1; r1op = 3'b111;
    tick();
    chk("slt_s1res", s1res, 32'd1);
    chk("slt_s1fl", {29'd0, s1fl}, {29'd0, 3'b000});
    r1v = 1'b0;
    tick();
    chk("drain_s1v", {31'd0, s1v}, 32'd0);

    // Round-robin contention: grants alternate starting with req0
    r0v = 1'b1; r0a = 32'hF0F0_F0F0; r0b = 32'hFF00_FF00; r0op = 3'b000;
    r1v = 1'b1; r1a = 32'h0000_000F; r1b = 32'h0000_00F0; r1op = 3'b001;
    #1;
    chk("rr1_q0rdy", {31'd0, q0rdy}, 32'd1);
    chk("rr1_q1rdy", {31'd0, q1rdy}, 32'd0);
    tick();
    chk("rr1_s0v", {31'd0, s0v}, 32'd1);
    chk("and_s0res", s0res, 32'hF000_F000);
    chk("and_s0fl", {29'd0, s0fl}, {29'd0, 3'b010});
    chk("rr1_s1v", {31'd0, s1v}, 32'd0);
    chk("rr2_q0rdy", {31'd0, q0rdy}, 32'd0);
    chk("rr2_q1rdy", {31'd0, q1rdy}, 32'd1);
    tick();
    chk("rr2_s1v", {31'd0, s1v}, 32'd1);
    chk("or_s1res", s1res, 32'h0000_00FF);
    chk("or_s1fl", {29'd0, s1fl}, {29'd0, 3'b000});
    chk("rr2_s0v", {31'd0, s0v}, 32'd0);
    chk("rr3_q0rdy", {31'd0, q0rdy}, 32'd1);
    chk("rr3_q1rdy", {31'd0, q1rdy}, 32'd0);
    tick();
    chk("rr3_s0v", {31'd0, s0v}, 32'd1);
    chk("rr3_s1v", {31'd0, s1v}, 32'd0);

    // Backpressure on slot 0 while req1 keeps streaming
    s0r = 1'b0; r0a = 32'h1234_5678; r0b = 32'hFFFF_FFFF; r0op = 3'b100;
    r1a = 32'd1; r1b = 32'd1; r1op = 3'b010;
    #1;
    chk("bp1_q0rdy", {31'd0, q0rdy}, 32'd0);
    chk("bp1_q1rdy", {31'd0, q1rdy}, 32'd1);
    tick();
    chk("bp1_s0v", {31'd0, s0v}, 32'd1);
    chk("bp1_s0res", s0res, 32'hF000_F000);
    chk("bp1_s0fl", {29'd0, s0fl}, {29'd0, 3'b010});
    chk("bp1_s1v", {31'd0, s1v}, 32'd1);
    chk("bp1_s1res", s1res, 32'd2);
    r1a = 32'd3; r1b = 32'd5; r1op = 3'b110;
    #1;
    chk("bp2_q0rdy", {31'd0, q0rdy}, 32'd0);
    chk("bp2_q1rdy", {31'd0, q1rdy}, 32'd1);
    tick();
    chk("bp2_s0res", s0res, 32'hF000_F000);
    chk("bp2_s1v", {31'd0, s1v}, 32'd1);
    chk("bp2_s1res", s1res, 32'hFFFF_FFFE);
    chk("bp2_s1fl", {29'd0, s1fl}, {29'd0, 3'b010});
    s0r = 1'b1; r1a = 32'd1; r1b = 32'd1; r1op = 3'b010;
    #1;
    chk("bp3_q0rdy", {31'd0, q0rdy}, 32'd0);
    chk("bp3_q1rdy", {31'd0, q1rdy}, 32'd1);
    tick();
    chk("bp3_s0v", {31'd0, s0v}, 32'd0);
    chk("bp3_s1res", s1res, 32'd2);
    chk("bp4_q0rdy", {31'd0, q0rdy}, 32'd1);
    chk("bp4_q1rdy", {31'd0, q1rdy}, 32'd0);
    tick();
    chk("xor_s0v", {31'd0, s0v}, 32'd1);
    chk("xor_s0res", s0res, 32'hEDCB_A987);
    chk("xor_s0fl", {29'd0, s0fl}, {29'd0, 3'b010});
    chk("bp4_s1v", {31'd0, s1v}, 32'd0);

    // Reset while slot 0 is full and both requests are pending
    s0r = 1'b0; rst = 1'b1;
    #1;
    chk("mid_rst_q0rdy", {31'd0, q0rdy}, 32'd0);
    chk("mid_rst_q1rdy", {31'd0, q1rdy}, 32'd0);
    chk("mid_rst_fq0rdy", {31'd0, fq0rdy}, 32'd0);
    tick();
    chk("mid_rst_s0v", {31'd0, s0v}, 32'd0);
    chk("mid_rst_s1v", {31'd0, s1v}, 32'd0);
    chk("mid_rst_fs0v", {31'd0, fs0v}, 32'd0);

    // Fixed priority: req0 wins every cycle; the round-robin pointer is back at req0
    rst = 1'b0; s0r = 1'b1; s1r = 1'b1;
    r0a = 32'd2; r0b = 32'd3; r0op = 3'b010;
    r1a = 32'h0000_000F; r1b = 32'h0000_00F0; r1op = 3'b001;
    #1;
    chk("rr_rst_q0rdy", {31'd0, q0rdy}, 32'd1);
    chk("rr_rst_q1rdy", {31'd0, q1rdy}, 32'd0);
    chk("fp0_q0rdy", {31'd0, fq0rdy}, 32'd1);
    chk("fp0_q1rdy", {31'd0, fq1rdy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fp_s0v", {31'd0, fs0v}, 32'd1);
      chk("fp_s0res", fs0res, 32'd5);
      chk("fp_q0rdy", {31'd0, fq0rdy}, 32'd1);
      chk("fp_q1rdy", {31'd0, fq1rdy}, 32'd0);
    end
    chk("fp_s0fl", {29'd0, fs0fl}, {29'd0, 3'b000});
    chk("fp_s1v_starved", {31'd0, fs1v}, 32'd0);
    r0v = 1'b0;
    #1;
    chk("fp_q1rdy_release", {31'd0, fq1rdy}, 32'd1);
    tick();
    chk("fp_s1v", {31'd0, fs1v}, 32'd1);
    chk("fp_s1res", fs1res, 32'h0000_00FF);
    chk("fp_s0v_drain", {31'd0, fs0v}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
